// File: rtl/fp_mul_stream_ctrl.sv
// fp_mul_stream_ctrl: credit-based stream controller for a 1-cycle FP multiplier; in_valid/in_ready/in_a/in_b queue operand pairs, mul_in_1/mul_in_2/mul_out talk to the multiplier, out_valid/out_ready/out_data deliver products in order, busy flags pending work
module fp_mul_stream_ctrl #(
  parameter int IN_DEPTH = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic        clk_pll,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [26:0] in_a,
  input  logic [26:0] in_b,
  output logic [26:0] mul_in_1,
  output logic [26:0] mul_in_2,
  input  logic [26:0] mul_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [26:0] out_data,
  output logic        busy
);
  localparam int IW = $clog2(IN_DEPTH);
  localparam int OW = $clog2(OUT_DEPTH);
  logic [53:0] r_in_mem [IN_DEPTH];
  logic [26:0] r_out_mem [OUT_DEPTH];
  logic [IW-1:0] r_in_wr, r_in_rd;
  logic [OW-1:0] r_out_wr, r_out_rd;
  logic [IW:0] r_in_count;
  logic [OW:0] r_out_count;
  logic r_inflight;
  logic w_push, w_pop, w_issue;
  logic [OW+1:0] w_used, w_cap;
  always_comb begin
    in_ready = (r_in_count < (IW+1)'(IN_DEPTH)) && !rst;
    w_push = in_valid && in_ready;
    out_valid = r_out_count != '0;
    out_data = r_out_mem[r_out_rd];
    w_pop = out_valid && out_ready;
    w_used = (OW+2)'(r_out_count) + (OW+2)'(r_inflight);
    w_cap = (OW+2)'(OUT_DEPTH) + (OW+2)'(w_pop);
    w_issue = (r_in_count != '0) && (w_used < w_cap);
    {mul_in_1, mul_in_2} = w_issue ? r_in_mem[r_in_rd] : 54'h0;
    busy = (r_in_count != '0) || r_inflight || out_valid;
  end
  always_ff @(posedge clk_pll) begin
    if (rst) begin
      r_in_wr <= '0;
      r_in_rd <= '0;
      r_in_count <= '0;
      r_out_wr <= '0;
      r_out_rd <= '0;
      r_out_count <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_in_wr <= r_in_wr + IW'(w_push);
      r_in_rd <= r_in_rd + IW'(w_issue);
      r_in_count <= r_in_count + (IW+1)'(w_push) - (IW+1)'(w_issue);
      r_out_wr <= r_out_wr + OW'(r_inflight);
      r_out_rd <= r_out_rd + OW'(w_pop);
      r_out_count <= r_out_count + (OW+1)'(r_inflight) - (OW+1)'(w_pop);
      r_inflight <= w_issue;
    end
  end
  always_ff @(posedge clk_pll) begin
    if (w_push) r_in_mem[r_in_wr] <= {in_a, in_b};
    if (r_inflight && !rst) r_out_mem[r_out_wr] <= mul_out;
  end
endmodule

// File: doc/fp_mul_stream_ctrl.md
FP_MUL_STREAM_CTRL -- requirements
Module: fp_mul_stream_ctrl

Interface
REQ-001 SHALL have parameter IN_DEPTH, default 4, operand-pair FIFO depth; power of two, at least 2.
REQ-002 SHALL have parameter OUT_DEPTH, default 2, result FIFO depth; power of two, at least 2.
REQ-003 SHALL have clock port clk_pll, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have reset port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have in_valid, input, 1 bit: operand pair on in_a/in_b is valid.
REQ-006 SHALL have in_ready, output, 1 bit: block accepts the pair this cycle.
REQ-007 SHALL have in_a and in_b, inputs, 27 bits each: operands, {sign[26], exp[25:18], fraction[17:0]}, explicit leading bit at fraction[17].
REQ-008 SHALL have mul_in_1 and mul_in_2, outputs, 27 bits each: operands driven to the downstream 1-cycle-latency floating-point multiplier.
REQ-009 SHALL have mul_out, input, 27 bits: multiplier result, valid in the cycle after an issue edge.
REQ-010 SHALL have out_valid, output, 1 bit: out_data holds a result.
REQ-011 SHALL have out_ready, input, 1 bit: consumer takes out_data this cycle.
REQ-012 SHALL have out_data, output, 27 bits: product, in input order.
REQ-013 SHALL have busy, output, 1 bit: any operand queued, any product in flight, or any result buffered.

Function
REQ-014 SHALL accept a pair on any edge where in_valid and in_ready are both 1.
REQ-015 SHALL compute in_ready = (in_count < IN_DEPTH) and not rst; when full, in_ready SHALL stay 0 even if a pop occurs in the same cycle (no full-bypass).
REQ-016 SHALL keep in_count (0..IN_DEPTH) and out_count (0..OUT_DEPTH) counters; read/write pointers SHALL wrap modulo depth.
REQ-017 SHALL compute credit = OUT_DEPTH - out_count - inflight + (out_valid and out_ready).
REQ-018 SHALL assert issue in a cycle iff in_count > 0 and credit > 0.
REQ-019 On issue, SHALL drive mul_in_1/mul_in_2 with the input FIFO head pair and pop it at that edge.
REQ-020 When not issuing, SHALL drive mul_in_1 and mul_in_2 to 27'h0.
REQ-021 SHALL register inflight <= issue each edge.
REQ-022 When inflight = 1, SHALL write mul_out into the result FIFO at that edge; with credit accounting this write never overflows.
REQ-023 SHALL drive out_valid = (out_count > 0) and out_data = result FIFO head; pop on out_valid and out_ready.
REQ-024 SHALL handle a simultaneous push and pop on either FIFO with the count unchanged.
REQ-025 Latency: a pair accepted at edge E into an empty block SHALL issue in the cycle after E and appear with out_valid = 1 after edge E+2.
REQ-026 Throughput: with in_valid and out_ready held at 1, SHALL sustain one result per cycle.
REQ-027 SHALL preserve strict FIFO order; no result is dropped or duplicated.
REQ-028 When out_ready = 0, SHALL stall issue once credit reaches 0; in_ready SHALL then drop after IN_DEPTH further accepts.

Reset
REQ-029 While rst = 1 at an edge, SHALL clear in_count, out_count, all pointers and inflight; in_ready SHALL be 0 while rst = 1.
REQ-030 After reset: in_ready = 1, out_valid = 0, busy = 0, mul_in_1 = mul_in_2 = 0; out_data value is don't-care while out_valid = 0.
REQ-031 Reset mid-operation SHALL discard queued pairs, the in-flight product and buffered results; no result SHALL appear after reset from pre-reset input.

Verification
REQ-032 Single op, bench with the real multiplier attached: in_a = 27'h5FE0000 (sign 1, exp 8'h7F, fraction 18'h20000), in_b = 27'h1FE0000 -> out_valid at E+2; out_data[26] = 1; out_data[17:0] = 18'h20000; exp matches the golden model.
REQ-033 Streaming: 16 back-to-back pairs with out_ready = 1 -> in_ready stays 1; 16 results on consecutive cycles in order.
REQ-034 Backpressure: out_ready = 0 while 8 pairs are offered -> 2 results buffered, in_ready = 0 after 6 accepts; release out_ready -> all 8 results in order, none lost.
REQ-035 Alternating out_ready = 1/0 with random in_valid -> ordering preserved; out_count never exceeds OUT_DEPTH; no write while full.
REQ-036 rst pulsed for 1 cycle with inflight = 1 and both FIFOs non-empty -> next cycle out_valid = 0, busy = 0, in_ready = 1; no stale output afterwards.
